// File: rtl/spi_slave_pkg.sv
// Shared constants and types for the SPI slave endpoint.
package spi_pkg;

    localparam int DATA_WIDTH_DEF = 8;

    // Pin levels the synchronizers hold in reset and while the bus is idle.
    localparam logic SCLK_IDLE = 1'b0;
    localparam logic CS_IDLE   = 1'b1;
    localparam logic MOSI_IDLE = 1'b0;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/spi_slave_if.sv
// SPI pins (except the tri-stated MISO pad) and the parallel load/receive port.
interface spi_slave_if #(
    parameter int DATA_WIDTH = spi_pkg::DATA_WIDTH_DEF
);
    logic                  SCLK;
    logic                  CS;
    logic                  MOSI;
    logic [DATA_WIDTH-1:0] txData;
    logic                  txLoad;
    logic [DATA_WIDTH-1:0] rxData;
    logic                  rxValid;
    logic                  busy;
    // Pad output enable that accompanies MISO; high exactly when MISO is driven.
    logic                  misoOe;

    modport slave (
        input  SCLK, CS, MOSI, txData, txLoad,
        output rxData, rxValid, busy, misoOe
    );

    modport master (
        output SCLK, CS, MOSI, txData, txLoad,
        input  rxData, rxValid, busy, misoOe
    );
endinterface

// File: rtl/spi_slave_edge_sync.sv
// Two-flop synchronizer plus one delay flop; yields the synchronized level
// and single-cycle rise/fall pulses for an asynchronous pin.
module spi_edge_sync
    import spi_pkg::*;
#(
    parameter logic IDLE_LVL = SCLK_IDLE
) (
    input  logic clk,
    input  logic reset,
    input  logic i_pin,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);
    logic r_meta;
    logic r_sync;
    logic r_dly;

    // Synchronize the pin and keep one cycle of history for edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_meta <= IDLE_LVL;
            r_sync <= IDLE_LVL;
            r_dly  <= IDLE_LVL;
        end else begin
            r_meta <= i_pin;
            r_sync <= r_meta;
            r_dly  <= r_sync;
        end
    end

    assign o_level = r_sync;
    assign o_rise  = r_sync & ~r_dly;
    assign o_fall  = ~r_sync & r_dly;
endmodule

// File: rtl/spi_slave.sv
// SPI mode-0, LSB-first slave endpoint running entirely in the clk domain.
//
// state | meaning
// IDLE  | chip select high, MISO released, waiting for CS to fall
// SHIFT | frame in progress, shifting on synchronized SCLK edges
module spi_slave
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic       clk,
    input  logic       reset,
    spi_slave_if.slave bus,
    output wire        MISO
);
    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    logic w_sclk_level, w_sclk_rise, w_sclk_fall;
    logic w_cs_level, w_cs_rise, w_cs_fall;
    logic w_unused_levels;

    logic r_mosi_meta, r_mosi_sync;

    state_t r_state, w_state_next;
    logic   w_active;

    logic [DATA_WIDTH-1:0] r_tx_buf;
    logic [DATA_WIDTH-1:0] r_tx_shift;
    logic [DATA_WIDTH-1:0] r_rx_shift;
    logic [DATA_WIDTH-1:0] r_rx_data;
    logic                  r_rx_valid;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_skip_fall;

    spi_edge_sync #(.IDLE_LVL(SCLK_IDLE)) u_sclk_sync (
        .clk     (clk),
        .reset   (reset),
        .i_pin   (bus.SCLK),
        .o_level (w_sclk_level),
        .o_rise  (w_sclk_rise),
        .o_fall  (w_sclk_fall)
    );

    spi_edge_sync #(.IDLE_LVL(CS_IDLE)) u_cs_sync (
        .clk     (clk),
        .reset   (reset),
        .i_pin   (bus.CS),
        .o_level (w_cs_level),
        .o_rise  (w_cs_rise),
        .o_fall  (w_cs_fall)
    );

    // Only the edges of SCLK and CS drive the controller.
    assign w_unused_levels = w_sclk_level ^ w_cs_level;

    // MOSI needs no edge detection, only a plain two-flop synchronizer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mosi_meta <= MOSI_IDLE;
            r_mosi_sync <= MOSI_IDLE;
        end else begin
            r_mosi_meta <= bus.MOSI;
            r_mosi_sync <= r_mosi_meta;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: CS edges alone move between idle and shifting.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_cs_fall) w_state_next = SHIFT;
            SHIFT:   if (w_cs_rise) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Output decode from the current state.
    always_comb begin
        w_active = 1'b0;
        case (r_state)
            SHIFT:   w_active = 1'b1;
            default: w_active = 1'b0;
        endcase
    end

    // Shift datapath, TX buffer and receive word register.
    // A CS rise coinciding with the final SCLK rise still completes the word,
    // since the SHIFT branch is evaluated in that same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tx_buf    <= '0;
            r_tx_shift  <= '0;
            r_rx_shift  <= '0;
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_cnt       <= '0;
            r_skip_fall <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            // Copies below read the old buffer, so a same-cycle load lands in
            // the buffer for the following word.
            if (bus.txLoad) begin
                r_tx_buf <= bus.txData;
            end
            case (r_state)
                IDLE: begin
                    if (w_cs_fall) begin
                        r_tx_shift  <= r_tx_buf;
                        r_cnt       <= '0;
                        r_skip_fall <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (w_sclk_rise) begin
                        r_rx_shift <= {r_mosi_sync, r_rx_shift[DATA_WIDTH-1:1]};
                        if (r_cnt == LAST_BIT) begin
                            r_cnt       <= '0;
                            r_rx_data   <= {r_mosi_sync, r_rx_shift[DATA_WIDTH-1:1]};
                            r_rx_valid  <= 1'b1;
                            // Next word's bit 0 must survive the trailing fall.
                            r_tx_shift  <= r_tx_buf;
                            r_skip_fall <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end else if (w_sclk_fall) begin
                        if (r_skip_fall) begin
                            r_skip_fall <= 1'b0;
                        end else begin
                            r_tx_shift <= r_tx_shift >> 1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.rxData  = r_rx_data;
    assign bus.rxValid = r_rx_valid;
    assign bus.busy    = w_active;
    assign bus.misoOe  = w_active;
    assign MISO        = w_active ? r_tx_shift[0] : 1'bz;
endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: directed scenarios plus randomized frames. Expected
// received words go into a queue popped by an rxValid monitor; the words the
// master should read back come from a model of the TX buffer.
module tb_spi_slave;
    import spi_pkg::*;

    localparam int W = DATA_WIDTH_DEF;
    localparam int H = 5;

    logic clk = 1'b0;
    logic reset;
    wire  w_miso;

    spi_slave_if #(.DATA_WIDTH(W)) bus();

    spi_slave #(.DATA_WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .MISO  (w_miso)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [W-1:0] rx_q[$];
    logic [W-1:0] model_buf;
    logic [W-1:0] model_rxdata;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic tx_load(input logic [W-1:0] v);
        bus.txData = v;
        bus.txLoad = 1'b1;
        cyc(1);
        bus.txLoad = 1'b0;
        model_buf  = v;
    endtask

    // Monitor: every rxValid pulse must match the oldest expected word.
    initial begin : monitor
        logic         prev_valid;
        logic [W-1:0] exp;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (reset === 1'b1 && bus.rxValid === 1'b1) begin
                if (prev_valid) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL rxValid_width: got high for 2+ cycles expected 1 cycle at %0t", $time);
                end else if (rx_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL rxValid_spurious: got pulse with rxData 0x%0h expected none at %0t",
                             bus.rxData, $time);
                end else begin
                    exp = rx_q.pop_front();
                    check("rxData", 32'(bus.rxData), 32'(exp));
                    model_rxdata = exp;
                end
            end
            prev_valid = (reset === 1'b1) ? bus.rxValid : 1'b0;
        end
    end

    // One CS-low transaction of nb bytes. Optionally loads ld_val during the
    // high phase of bit ld_bit of byte ld_byte, and optionally raises CS
    // together with the final SCLK rise.
    task automatic xfer(input logic [7:0] a0, input logic [7:0] a1, input logic [7:0] a2,
                        input int nb, input int ld_byte, input int ld_bit,
                        input logic [7:0] ld_val, input bit fast_end);
        logic [7:0] mo[3];
        logic [7:0] got;
        logic [7:0] exp_tx;
        mo[0] = a0;
        mo[1] = a1;
        mo[2] = a2;
        got   = '0;
        bus.CS   = 1'b0;
        bus.MOSI = mo[0][0];
        cyc(2);
        check("busy_before_sync", 32'(bus.busy), 32'd0);
        cyc(1);
        check("busy_rise", 32'(bus.busy), 32'd1);
        check("miso_oe_on", 32'(bus.misoOe), 32'd1);
        cyc(H - 3);
        for (int b = 0; b < nb; b++) begin
            exp_tx = model_buf;
            rx_q.push_back(mo[b]);
            for (int i = 0; i < 8; i++) begin
                bus.MOSI = mo[b][i];
                if (!(b == 0 && i == 0)) cyc(H);
                bus.SCLK = 1'b1;
                if (fast_end && b == nb - 1 && i == 7) bus.CS = 1'b1;
                got[i] = w_miso;
                if (i == 7) begin
                    cyc(2);
                    check("rxValid_early", 32'(bus.rxValid), 32'd0);
                    cyc(1);
                    check("rxValid_pulse", 32'(bus.rxValid), 32'd1);
                    if (fast_end && b == nb - 1)
                        check("busy_fast_end", 32'(bus.busy), 32'd0);
                    cyc(H - 3);
                end else if (b == ld_byte && i == ld_bit) begin
                    tx_load(ld_val);
                    cyc(H - 1);
                end else begin
                    cyc(H);
                end
                bus.SCLK = 1'b0;
            end
            check("master_rx", 32'(got), 32'(exp_tx));
        end
        cyc(H);
        if (!fast_end) begin
            bus.CS = 1'b1;
            cyc(2);
            check("busy_hold", 32'(bus.busy), 32'd1);
            cyc(1);
            check("busy_fall", 32'(bus.busy), 32'd0);
            check("miso_oe_off", 32'(bus.misoOe), 32'd0);
        end
        cyc(H);
    endtask

    // Frame abandoned after nr SCLK rises: nothing may be reported.
    task automatic abort_frame(input int nr);
        bus.CS   = 1'b0;
        bus.MOSI = 1'($urandom);
        cyc(H);
        for (int i = 0; i < nr; i++) begin
            bus.SCLK = 1'b1;
            cyc(H);
            bus.SCLK = 1'b0;
            bus.MOSI = 1'($urandom);
            cyc(H);
        end
        bus.CS = 1'b1;
        cyc(4);
        check("abort_miso_oe", 32'(bus.misoOe), 32'd0);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_rxData", 32'(bus.rxData), 32'(model_rxdata));
        cyc(H);
    endtask

    // Reset pulled in the middle of a frame after three bits.
    task automatic reset_mid_frame();
        bus.CS   = 1'b0;
        bus.MOSI = 1'b1;
        cyc(H);
        for (int i = 0; i < 3; i++) begin
            bus.SCLK = 1'b1;
            cyc(H);
            bus.SCLK = 1'b0;
            bus.MOSI = 1'($urandom);
            cyc(H);
        end
        reset = 1'b0;
        #1;
        check("rst_mid_miso_oe", 32'(bus.misoOe), 32'd0);
        check("rst_mid_busy", 32'(bus.busy), 32'd0);
        check("rst_mid_rxData", 32'(bus.rxData), 32'd0);
        check("rst_mid_rxValid", 32'(bus.rxValid), 32'd0);
        bus.SCLK = SCLK_IDLE;
        bus.CS   = CS_IDLE;
        bus.MOSI = 1'b0;
        cyc(2);
        reset        = 1'b1;
        model_buf    = '0;
        model_rxdata = '0;
        cyc(4);
    endtask

    initial begin : stim
        int         nb;
        int         ldb;
        int         ldi;
        bit         fast;
        reset        = 1'b0;
        bus.SCLK     = SCLK_IDLE;
        bus.CS       = CS_IDLE;
        bus.MOSI     = 1'b0;
        bus.txData   = '0;
        bus.txLoad   = 1'b0;
        model_buf    = '0;
        model_rxdata = '0;

        cyc(3);
        check("rst_miso_oe", 32'(bus.misoOe), 32'd0);
        check("rst_rxData", 32'(bus.rxData), 32'd0);
        check("rst_rxValid", 32'(bus.rxValid), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        reset = 1'b1;
        cyc(6);
        check("post_rst_busy", 32'(bus.busy), 32'd0);
        check("post_rst_rxData", 32'(bus.rxData), 32'd0);
        check("post_rst_miso_oe", 32'(bus.misoOe), 32'd0);

        // Single byte: returns 0x53, receives 0x27.
        tx_load(8'h53);
        xfer(8'h27, 8'h00, 8'h00, 1, -1, 0, 8'h00, 1'b0);

        // Back-to-back bytes with a load mid first byte.
        xfer(8'hA5, 8'h3C, 8'h00, 2, 0, 3, 8'h0F, 1'b0);

        // Partial frame then a full one.
        abort_frame(5);
        xfer(8'hC3, 8'h00, 8'h00, 1, -1, 0, 8'h00, 1'b0);

        // Reset mid-frame, then a frame returning the cleared buffer.
        tx_load(8'h53);
        reset_mid_frame();
        xfer(8'h81, 8'h00, 8'h00, 1, -1, 0, 8'h00, 1'b0);

        // Load during bit 4 only affects the next frame.
        tx_load(8'h53);
        xfer(8'h5A, 8'h00, 8'h00, 1, 0, 4, 8'hFF, 1'b0);
        xfer(8'h96, 8'h00, 8'h00, 1, -1, 0, 8'h00, 1'b0);

        // CS rises together with the final SCLK rise.
        xfer(8'h6E, 8'h00, 8'h00, 1, -1, 0, 8'h00, 1'b1);

        for (int r = 0; r < 24; r++) begin
            if ($urandom_range(1, 0) == 1) tx_load(8'($urandom));
            nb   = int'($urandom_range(3, 1));
            ldb  = int'($urandom_range(3, 0));
            ldi  = int'($urandom_range(6, 0));
            fast = ($urandom_range(3, 0) == 0);
            if (ldb == 3) ldb = -1;
            if ($urandom_range(5, 0) == 0) abort_frame(int'($urandom_range(7, 1)));
            xfer(8'($urandom), 8'($urandom), 8'($urandom), nb, ldb, ldi, 8'($urandom), fast);
        end

        cyc(10);
        check("rx_queue_drained", 32'(rx_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
